// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one pipeline stage register with a valid/ready handshake
// and a 2-entry skid buffer (main + skid). in_ready depends only on the stage
// state, so back-pressure never forms a combinational path through the stage.
// The stage also supports flush, start-gated bubble insertion and two
// saturating debug counters.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   start      in   run enable; 0 empties the stage and emits bubbles
//   flush      in   synchronous kill of held and incoming entries
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept this cycle
//   in_data    in   upstream payload (WIDTH bits, low CTRL_W are control)
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   downstream accepts this cycle
//   out_data   out  payload to next stage
//   stall_cnt  out  cycles with out_valid=1 and out_ready=0, saturating
//   bubble_cnt out  cycles with start=1 and out_valid=0, saturating
module pipe_skid_stage #(
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned CTRL_W     = 24,
    parameter bit          CLEAR_DATA = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   bubble_q, bubble_d;

    logic accept;
    logic drain;
    logic kill;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    // Next-state and payload steering
    always_comb begin
        accept  = in_valid & in_ready;
        drain   = out_valid & out_ready;
        kill    = flush | ~start;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        // A killed cycle only empties the stage; main keeps its contents so
        // the data bits can hold when CLEAR_DATA=0.
        if (kill) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_d  = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = SKID;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Counters look at the pre-override handshake state.
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (start && !out_valid && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q != SKID);
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        if (!out_valid) begin
            if (CLEAR_DATA) begin
                out_data = '0;
            end else begin
                out_data[CTRL_W-1:0] = '0;
            end
        end
        stall_cnt  = stall_q;
        bubble_cnt = bubble_q;
    end

endmodule
